// File: rtl/uart_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module  : uart_reg_bridge
// Brief   : Byte-stream command bridge giving a UART host read/write access
//           to a bank of registers plus a read-only version register.
// Revision: 1.0 - initial release
// ============================================================================
module uart_reg_bridge #(
  parameter int                              NUM_BYTES_PER_REG = 4,
  parameter int                              NUM_REGISTERS     = 8,
  parameter logic [NUM_BYTES_PER_REG*8-1:0]  VERSION           = '0,
  parameter int                              TIMEOUT_CYCLES    = 100000
) (
  input  logic                                          clock,
  input  logic                                          arst_n,
  input  logic [7:0]                                    uart_rx_value,
  input  logic                                          uart_rx_value_ready,
  output logic [7:0]                                    uart_tx_value,
  output logic                                          uart_tx_value_write,
  input  logic                                          uart_tx_value_done,
  input  logic [NUM_REGISTERS*NUM_BYTES_PER_REG*8-1:0]  value_in,
  output logic [NUM_REGISTERS*NUM_BYTES_PER_REG*8-1:0]  value_out,
  output logic [NUM_REGISTERS-1:0]                      value_wr_strobe
);

  localparam int               c_NB      = NUM_BYTES_PER_REG;
  localparam int               c_DW      = c_NB * 8;
  localparam int               c_CNT_W   = (c_NB > 1) ? $clog2(c_NB) : 1;
  localparam int               c_TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(c_NB - 1);
  localparam logic [7:0]       c_MAX_IDX = 8'(NUM_REGISTERS);
  localparam logic [7:0]       c_CH_S    = 8'h53;
  localparam logic [7:0]       c_CH_W    = 8'h57;
  localparam logic [7:0]       c_CH_R    = 8'h52;
  localparam logic [7:0]       c_CH_K    = 8'h4B;
  localparam logic [7:0]       c_CH_E    = 8'h45;

  if (NUM_BYTES_PER_REG < 1 || NUM_BYTES_PER_REG > 8 ||
      (NUM_BYTES_PER_REG & (NUM_BYTES_PER_REG - 1)) != 0) begin : g_bad_nb
    $error("uart_reg_bridge: NUM_BYTES_PER_REG=%0d must be a power of two in 1..8",
           NUM_BYTES_PER_REG);
  end
  if (NUM_REGISTERS < 1 || NUM_REGISTERS > 255) begin : g_bad_nr
    $error("uart_reg_bridge: NUM_REGISTERS=%0d must be in 1..255", NUM_REGISTERS);
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INDEX     = 3'd1,
    ACTION    = 3'd2,
    RECV      = 3'd3,
    COMMIT    = 3'd4,
    RESP_LOAD = 3'd5,
    RESP_SEND = 3'd6,
    RESP_WAIT = 3'd7
  } state_t;

  state_t                              r_state;
  state_t                              w_next;
  logic [7:0]                          r_idx;
  logic [c_CNT_W-1:0]                  r_cnt;
  logic [c_CNT_W-1:0]                  r_last;
  logic [c_DW-1:0]                     r_shadow;
  logic [c_DW-1:0]                     r_tx_buf;
  logic [NUM_REGISTERS*c_DW-1:0]       r_value;
  logic [NUM_REGISTERS-1:0]            w_sel;
  logic [NUM_REGISTERS-1:0]            w_strobe;
  logic [c_DW-1:0]                     w_rd_word;
  logic [7:0]                          w_tx_byte;
  logic                                w_tx_write;
  logic                                w_waiting;
  logic                                w_timeout;

  assign w_waiting = (r_state == INDEX) || (r_state == ACTION) || (r_state == RECV);

  // Idle-cycle counter; any rx byte reloads it, so a byte always beats expiry.
  if (TIMEOUT_CYCLES > 0) begin : g_timeout
    logic [c_TO_W-1:0] r_to_cnt;

    always_ff @(posedge clock or negedge arst_n) begin
      if (!arst_n) begin
        r_to_cnt <= '0;
      end else if (uart_rx_value_ready || !w_waiting) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + c_TO_W'(1);
      end
    end

    assign w_timeout = w_waiting && !uart_rx_value_ready &&
                       (r_to_cnt == c_TO_W'(TIMEOUT_CYCLES));
  end else begin : g_no_timeout
    assign w_timeout = 1'b0;
  end

  // Full 8-bit index decode: out-of-range indices select nothing.
  always_comb begin
    w_sel     = '0;
    w_rd_word = VERSION;
    for (int r = 0; r < NUM_REGISTERS; r++) begin
      w_sel[r] = (r_idx == 8'(r));
      if (w_sel[r]) begin
        w_rd_word = value_in[r*c_DW +: c_DW];
      end
    end
  end

  assign w_tx_byte = r_tx_buf[{r_cnt, 3'b000} +: 8];

  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_tx_write = 1'b0;
    w_strobe   = '0;
    case (r_state)
      IDLE: begin
        if (uart_rx_value_ready && uart_rx_value == c_CH_S) w_next = INDEX;
      end
      INDEX: begin
        if (uart_rx_value_ready) w_next = ACTION;
        else if (w_timeout)      w_next = IDLE;
      end
      ACTION: begin
        if (uart_rx_value_ready) begin
          if (uart_rx_value == c_CH_R && r_idx <= c_MAX_IDX)      w_next = RESP_LOAD;
          else if (uart_rx_value == c_CH_W && r_idx < c_MAX_IDX)  w_next = RECV;
          else                                                    w_next = RESP_SEND;
        end else if (w_timeout) begin
          w_next = IDLE;
        end
      end
      RECV: begin
        if (uart_rx_value_ready) begin
          if (r_cnt == c_LAST) w_next = COMMIT;
        end else if (w_timeout) begin
          w_next = IDLE;
        end
      end
      COMMIT: begin
        w_strobe = w_sel;
        w_next   = RESP_SEND;
      end
      RESP_LOAD: w_next = RESP_SEND;
      RESP_SEND: begin
        w_tx_write = 1'b1;
        w_next     = RESP_WAIT;
      end
      RESP_WAIT: begin
        if (uart_tx_value_done) w_next = (r_cnt == r_last) ? IDLE : RESP_SEND;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) begin
      r_idx    <= '0;
      r_cnt    <= '0;
      r_last   <= '0;
      r_shadow <= '0;
      r_tx_buf <= '0;
      r_value  <= '0;
    end else begin
      if (w_timeout) r_shadow <= '0;
      case (r_state)
        INDEX: begin
          if (uart_rx_value_ready) r_idx <= uart_rx_value;
        end
        ACTION: begin
          // Preload the error reply; the read path overwrites it in RESP_LOAD.
          if (uart_rx_value_ready) begin
            r_cnt    <= '0;
            r_last   <= '0;
            r_tx_buf <= c_DW'(c_CH_E);
          end
        end
        RECV: begin
          if (uart_rx_value_ready) begin
            r_shadow[{r_cnt, 3'b000} +: 8] <= uart_rx_value;
            r_cnt                          <= r_cnt + c_CNT_W'(1);
          end
        end
        COMMIT: begin
          for (int r = 0; r < NUM_REGISTERS; r++) begin
            if (w_sel[r]) r_value[r*c_DW +: c_DW] <= r_shadow;
          end
          r_tx_buf <= c_DW'(c_CH_K);
          r_cnt    <= '0;
          r_last   <= '0;
        end
        RESP_LOAD: begin
          r_tx_buf <= w_rd_word;
          r_cnt    <= '0;
          r_last   <= c_LAST;
        end
        RESP_WAIT: begin
          if (uart_tx_value_done && r_cnt != r_last) r_cnt <= r_cnt + c_CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign value_out           = r_value;
  assign value_wr_strobe     = w_strobe;
  assign uart_tx_value_write = w_tx_write;
  assign uart_tx_value       = w_tx_write ? w_tx_byte : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_uart_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_reg_bridge
// Brief   : Scoreboard bench for uart_reg_bridge (directed command vectors).
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_reg_bridge;

  localparam int NB = 4;
  localparam int NR = 8;
  localparam int DW = NB * 8;

  logic              clock = 1'b0;
  logic              arst_n = 1'b0;
  logic [7:0]        uart_rx_value = 8'h00;
  logic              uart_rx_value_ready = 1'b0;
  logic [7:0]        uart_tx_value;
  logic              uart_tx_value_write;
  logic              uart_tx_value_done = 1'b0;
  logic [NR*DW-1:0]  value_in;
  logic [NR*DW-1:0]  value_out;
  logic [NR-1:0]     value_wr_strobe;

  uart_reg_bridge #(
    .NUM_BYTES_PER_REG (NB),
    .NUM_REGISTERS     (NR),
    .VERSION           (32'hCAFE0001),
    .TIMEOUT_CYCLES    (50)
  ) dut (
    .clock               (clock),
    .arst_n              (arst_n),
    .uart_rx_value       (uart_rx_value),
    .uart_rx_value_ready (uart_rx_value_ready),
    .uart_tx_value       (uart_tx_value),
    .uart_tx_value_write (uart_tx_value_write),
    .uart_tx_value_done  (uart_tx_value_done),
    .value_in            (value_in),
    .value_out           (value_out),
    .value_wr_strobe     (value_wr_strobe)
  );

  assign value_in = value_out;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // mode 0: no timing check, 1: first read byte, 2: byte following a done
  typedef struct { logic [7:0] data; int mode; } tx_exp_t;
  typedef struct { int idx; logic [31:0] data; } wr_exp_t;
  tx_exp_t tx_q[$];
  wr_exp_t wr_q[$];

  int r_edge_cyc    = 0;
  int done_edge_cyc = 0;
  int tx_seen       = 0;
  int resp_cnt      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transmit monitor
  always @(negedge clock) begin
    if (uart_tx_value_write === 1'b1) begin
      tx_seen++;
      if (tx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected: got %02h expected no request", uart_tx_value);
      end else begin
        tx_exp_t e;
        e = tx_q.pop_front();
        check("tx_byte", uart_tx_value, e.data);
        if (e.mode == 1)      check("tx_first_latency", cyc, r_edge_cyc + 1);
        else if (e.mode == 2) check("tx_next_latency", cyc, done_edge_cyc);
      end
    end
  end

  // Strobe monitor; register contents checked the cycle after the strobe
  logic        chk_pend = 1'b0;
  int          chk_idx  = 0;
  logic [31:0] chk_data = '0;
  always @(negedge clock) begin
    if (chk_pend) begin
      check("value_out_commit", value_out[chk_idx*DW +: DW], chk_data);
      chk_pend = 1'b0;
    end
    if (value_wr_strobe !== '0) begin
      if (wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL strobe_unexpected: got %0h expected 0", value_wr_strobe);
      end else begin
        wr_exp_t w;
        w = wr_q.pop_front();
        check("strobe", value_wr_strobe, NR'(1) << w.idx);
        chk_pend = 1'b1;
        chk_idx  = w.idx;
        chk_data = w.data;
      end
    end
  end

  // Transmitter model: done pulse a few cycles after each request
  always @(negedge clock) begin
    if (uart_tx_value_done) uart_tx_value_done = 1'b0;
    if (uart_tx_value_write === 1'b1) begin
      resp_cnt = 3;
    end else if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        uart_tx_value_done = 1'b1;
        done_edge_cyc      = cyc + 1;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    uart_rx_value       = b;
    uart_rx_value_ready = 1'b1;
    @(negedge clock);
    uart_rx_value_ready = 1'b0;
    uart_rx_value       = 8'h00;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((tx_q.size() != 0 || wr_q.size() != 0) && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", tx_q.size() + wr_q.size());
    end
    repeat (8) @(negedge clock);
  endtask

  task automatic do_write(input logic [7:0] idx, input logic [31:0] data);
    wr_exp_t w;
    tx_exp_t e;
    w.idx = int'(idx);
    w.data = data;
    wr_q.push_back(w);
    e.data = "K";
    e.mode = 0;
    tx_q.push_back(e);
    send_byte("S");
    send_byte(idx);
    send_byte("W");
    for (int i = 0; i < NB; i++) send_byte(data[i*8 +: 8]);
  endtask

  task automatic do_read(input logic [7:0] idx, input logic [31:0] data);
    tx_exp_t e;
    for (int i = 0; i < NB; i++) begin
      e.data = data[i*8 +: 8];
      e.mode = (i == 0) ? 1 : 2;
      tx_q.push_back(e);
    end
    send_byte("S");
    send_byte(idx);
    send_byte("R");
    r_edge_cyc = cyc;
    wait_drain();
  endtask

  task automatic err_cmd(input logic [7:0] idx, input logic [7:0] act);
    tx_exp_t e;
    e.data = "E";
    e.mode = 0;
    tx_q.push_back(e);
    send_byte("S");
    send_byte(idx);
    send_byte(act);
    wait_drain();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clock);
    check("rst_value_out", value_out, '0);
    check("rst_strobe", value_wr_strobe, '0);
    check("rst_tx_write", uart_tx_value_write, 1'b0);
    check("rst_tx_value", uart_tx_value, 8'h00);
    arst_n = 1'b1;

    // Noise in IDLE is ignored
    send_byte(8'h00);
    send_byte("x");

    // Write reg2; an "S" arriving during the K response must be dropped
    do_write(8'd2, 32'h44332211);
    send_byte("S");
    wait_drain();
    check("reg2_after_write", value_out[2*DW +: DW], 32'h44332211);
    do_read(8'd2, 32'h44332211);

    do_write(8'd1, 32'h0A0B0C0D);
    wait_drain();

    // Version register
    do_read(8'd8, 32'hCAFE0001);

    // Error cases, including indices that alias under truncation
    err_cmd(8'd9, "R");
    err_cmd(8'd8, "W");
    err_cmd(8'd1, "X");
    err_cmd(8'h88, "R");
    err_cmd(8'h82, "W");
    check("reg2_no_alias", value_out[2*DW +: DW], 32'h44332211);

    // Timeout mid-write
    send_byte("S");
    send_byte(8'd1);
    send_byte("W");
    send_byte(8'hAA);
    repeat (60) @(negedge clock);
    check("reg1_after_timeout", value_out[1*DW +: DW], 32'h0A0B0C0D);
    do_read(8'd1, 32'h0A0B0C0D);

    // Reset while a read response is in flight, after B1 is requested
    begin
      tx_exp_t e;
      int base;
      int n;
      e.data = 8'h11; e.mode = 1; tx_q.push_back(e);
      e.data = 8'h22; e.mode = 2; tx_q.push_back(e);
      base = tx_seen;
      send_byte("S");
      send_byte(8'd2);
      send_byte("R");
      r_edge_cyc = cyc;
      n = 0;
      while (tx_seen < base + 2 && n < 100) begin
        @(negedge clock);
        n++;
      end
      check("reset_wait_b1", tx_seen - base, 2);
      arst_n = 1'b0;
      #1;
      check("midrst_value_out", value_out, '0);
      check("midrst_tx_write", uart_tx_value_write, 1'b0);
      @(negedge clock);
      arst_n = 1'b1;
      repeat (20) @(negedge clock);
      check("postrst_tx_queue", tx_q.size(), 0);
      check("postrst_value_out", value_out, '0);
    end

    do_write(8'd5, 32'hDEADBEEF);
    wait_drain();
    do_read(8'd5, 32'hDEADBEEF);

    check("final_tx_queue", tx_q.size(), 0);
    check("final_wr_queue", wr_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
